cnt_run_arbiter: RTL and testbench

- Shares one start/stop-controlled 4-bit mod-14 event counter between NREQ requesters.
- Each requester asks for a run of a given number of counter increments.
- The arbiter picks a requester round-robin and sequences the counter's start and stop pins. It then waits for the counter's two-stage delayed stop acknowledge before reporting completion.
- Sits directly beside the counter in the counting subsystem; the counter's own reset stays separate.

---
 rtl/cnt_run_arbiter_pkg.sv | 29 ++
 rtl/cnt_run_arbiter_rr_pick.sv | 40 ++++
 rtl/cnt_run_arbiter.sv | 155 +++++++++++++++
 tb/tb_cnt_run_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_run_arbiter_pkg.sv
// ============================================================================
//  Module   : cnt_run_arb_pkg
//  Purpose  : Shared types and constants for the counter run arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_run_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Cycles to wait for the delayed stop acknowledge before giving up
  localparam int DRAIN_TIMEOUT = 4;

  // Width of a requester index; never below one bit
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_run_arbiter_rr_pick.sv
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker. Searches last+1, last+2, ...
//             (wrapping) and returns the first set request as one-hot + index.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int k;

  // Rotating priority search starting just after the previous winner
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = 0;
    for (int off = 1; off <= N; off++) begin
      k = (int'(last) + off) % N;
      if (!valid && req[k]) begin
        valid     = 1'b1;
        idx       = IW'(k);
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cnt_run_arbiter.sv
// ============================================================================
//  Module   : cnt_run_arbiter
//  Purpose  : Shares one start/stop mod-14 event counter between NREQ
//             requesters. Grants round-robin, issues start, counts the
//             requested number of increments, issues stop and waits for the
//             counter's two-cycle delayed stop acknowledge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_run_arbiter
  import cnt_run_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int LEN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*LEN_W-1:0]    len,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     done,
  output logic [idx_w(NREQ)-1:0]   done_id,
  output logic                     aborted,
  output logic [LEN_W-1:0]         ticks,
  output logic                     cnt_start,
  output logic                     cnt_stop,
  input  logic                     cnt_stop_d2
);

  localparam int IW     = idx_w(NREQ);
  localparam int DCNT_W = $clog2(DRAIN_TIMEOUT);

  state_t             state, next_state;
  logic [IW-1:0]      winner, last;
  logic [NREQ-1:0]    win_oh;
  logic [LEN_W-1:0]   rem, tick_cnt;
  logic               aborted_r;
  logic [DCNT_W-1:0]  dcnt;

  logic [NREQ-1:0]    pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic [LEN_W-1:0]   pick_len;
  logic               cancel, timeout;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .last   (last),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign pick_len = len[int'(pick_idx)*LEN_W +: LEN_W];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode and counter pin sequencing
  always_comb begin
    next_state = state;
    grant      = '0;
    busy       = (state != IDLE);
    done       = 1'b0;
    cnt_start  = 1'b0;
    cnt_stop   = 1'b0;
    cancel     = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) next_state = (pick_len != '0) ? START : DONE;
      end
      START: begin
        grant      = win_oh;
        cnt_start  = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        grant = win_oh;
        // A normal end takes precedence over a simultaneous cancel
        if (rem == LEN_W'(1)) begin
          cnt_stop   = 1'b1;
          next_state = DRAIN;
        end else if (!req[winner]) begin
          cnt_stop   = 1'b1;
          cancel     = 1'b1;
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        grant = win_oh;
        if (cnt_stop_d2) begin
          next_state = DONE;
        end else if (dcnt == DCNT_W'(DRAIN_TIMEOUT - 1)) begin
          timeout    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Run bookkeeping: owner, remaining length, issued ticks, abort flag
  always_ff @(posedge clk) begin
    if (rst) begin
      winner    <= '0;
      win_oh    <= '0;
      last      <= IW'(NREQ - 1);
      rem       <= '0;
      tick_cnt  <= '0;
      aborted_r <= 1'b0;
      dcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            winner    <= pick_idx;
            win_oh    <= pick_oh;
            last      <= pick_idx;
            rem       <= pick_len;
            tick_cnt  <= '0;
            aborted_r <= 1'b0;
          end
        end
        RUN: begin
          tick_cnt <= tick_cnt + LEN_W'(1);
          rem      <= rem - LEN_W'(1);
          dcnt     <= '0;
          if (cancel) aborted_r <= 1'b1;
        end
        DRAIN: begin
          if (timeout) aborted_r <= 1'b1;
          else         dcnt      <= dcnt + DCNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ticks   = tick_cnt;
  assign done_id = (state == DONE) ? winner : '0;
  assign aborted = (state == DONE) & aborted_r;

endmodule

`default_nettype wire

// File: tb/tb_cnt_run_arbiter.sv
// ============================================================================
//  Module   : tb_cnt_run_arbiter
//  Purpose  : Directed self-checking bench for cnt_run_arbiter with a small
//             mod-14 start/stop counter model attached to its pins.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt_run_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] len = '0;
  logic [3:0]  grant;
  logic        busy, done, aborted, cnt_start, cnt_stop, cnt_stop_d2;
  logic [1:0]  done_id;
  logic [7:0]  ticks;

  // attached counter model
  logic        cnt_rst = 1'b1;
  logic        cnt_run;
  logic [3:0]  cnt_val;
  logic [1:0]  stop_pipe;
  logic        d2_low = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cnt_run_arbiter #(.NREQ(4), .LEN_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .len         (len),
    .grant       (grant),
    .busy        (busy),
    .done        (done),
    .done_id     (done_id),
    .aborted     (aborted),
    .ticks       (ticks),
    .cnt_start   (cnt_start),
    .cnt_stop    (cnt_stop),
    .cnt_stop_d2 (cnt_stop_d2)
  );

  assign cnt_stop_d2 = d2_low ? 1'b0 : stop_pipe[1];

  // Counter: counts every cycle after start, including the stop cycle
  always @(posedge clk) begin
    if (cnt_rst) begin
      cnt_val   <= '0;
      cnt_run   <= 1'b0;
      stop_pipe <= '0;
    end else begin
      stop_pipe <= {stop_pipe[0], cnt_stop};
      if (cnt_start) begin
        cnt_run <= 1'b1;
      end else if (cnt_stop) begin
        cnt_run <= 1'b0;
        cnt_val <= (cnt_val == 4'd13) ? 4'd0 : cnt_val + 4'd1;
      end else if (cnt_run) begin
        cnt_val <= (cnt_val == 4'd13) ? 4'd0 : cnt_val + 4'd1;
      end
    end
  end

  // Clears the counter model; leaves the caller just after a rising edge
  task automatic clr_counter();
    @(posedge clk); #1 cnt_rst = 1'b1;
    @(posedge clk); #1 cnt_rst = 1'b0;
  endtask

  // Observes one run. Cycle 0 is the cycle after the request was presented.
  // len is scrambled in cycle 1 to show it is only sampled at grant.
  task automatic watch(input int drop_at, input int drop_idx, input int max_cyc,
                       output int t_start, output int t_stop, output int t_done,
                       output logic [1:0] id, output logic [7:0] tk,
                       output logic ab, output logic [3:0] g_start,
                       output int n_over);
    t_start = -1; t_stop = -1; t_done = -1;
    id = '0; tk = '0; ab = 1'b0; g_start = '0; n_over = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      if (c == 1) len = ~len;
      if (c == drop_at) req[drop_idx] = 1'b0;
      @(negedge clk);
      if (cnt_start && cnt_stop) n_over++;
      if (cnt_start && t_start < 0) begin t_start = c; g_start = grant; end
      if (cnt_stop && t_stop < 0) t_stop = c;
      if (done) begin
        t_done = c; id = done_id; tk = ticks; ab = aborted;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (grant !== 4'b0)     begin n_fail++; $display("FAIL reset_grant got %b want 0000", grant); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (aborted !== 1'b0)   begin n_fail++; $display("FAIL reset_aborted got %b want 0", aborted); end
    n_checks++; if ({cnt_start, cnt_stop} !== 2'b00) begin n_fail++; $display("FAIL reset_pins got %b want 00", {cnt_start, cnt_stop}); end
    n_checks++; if (ticks !== 8'd0)     begin n_fail++; $display("FAIL reset_ticks got %0d want 0", ticks); end
    n_checks++; if (done_id !== 2'd0)   begin n_fail++; $display("FAIL reset_done_id got %0d want 0", done_id); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    int ts, tp, td, ov; logic [1:0] id; logic [7:0] tk; logic ab; logic [3:0] gs;
    clr_counter();
    len = 32'd5; req = 4'b0001;
    watch(-1, 0, 40, ts, tp, td, id, tk, ab, gs, ov);
    @(posedge clk); #1 req = '0;
    n_checks++; if (ts !== 0)        begin n_fail++; $display("FAIL single_start_cyc got %0d want 0", ts); end
    n_checks++; if (gs !== 4'b0001)  begin n_fail++; $display("FAIL single_grant got %b want 0001", gs); end
    n_checks++; if (tp !== 5)        begin n_fail++; $display("FAIL single_stop_cyc got %0d want 5", tp); end
    n_checks++; if (td !== 8)        begin n_fail++; $display("FAIL single_done_cyc got %0d want 8", td); end
    n_checks++; if (id !== 2'd0)     begin n_fail++; $display("FAIL single_done_id got %0d want 0", id); end
    n_checks++; if (tk !== 8'd5)     begin n_fail++; $display("FAIL single_ticks got %0d want 5", tk); end
    n_checks++; if (ab !== 1'b0)     begin n_fail++; $display("FAIL single_aborted got %b want 0", ab); end
    n_checks++; if (cnt_val !== 4'd5) begin n_fail++; $display("FAIL single_counter got %0d want 5", cnt_val); end
    n_checks++; if (ov !== 0)        begin n_fail++; $display("FAIL single_start_stop_overlap got %0d want 0", ov); end
  endtask

  task automatic test_wrap();
    int ts, tp, td, ov; logic [1:0] id; logic [7:0] tk; logic ab; logic [3:0] gs;
    clr_counter();
    len = 32'd20; req = 4'b0001;
    watch(-1, 0, 60, ts, tp, td, id, tk, ab, gs, ov);
    @(posedge clk); #1 req = '0;
    n_checks++; if (tp !== 20)        begin n_fail++; $display("FAIL wrap_stop_cyc got %0d want 20", tp); end
    n_checks++; if (td !== 23)        begin n_fail++; $display("FAIL wrap_done_cyc got %0d want 23", td); end
    n_checks++; if (tk !== 8'd20)     begin n_fail++; $display("FAIL wrap_ticks got %0d want 20", tk); end
    n_checks++; if (cnt_val !== 4'd6) begin n_fail++; $display("FAIL wrap_counter got %0d want 6", cnt_val); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    logic [1:0] got_id [6];
    int         t_d    [6];
    int         nd = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    clr_counter();
    len = {8'd1, 8'd1, 8'd1, 8'd1}; req = 4'b1011;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (nd == 6) begin req = '0; break; end
      @(negedge clk);
      if (done) begin got_id[nd] = done_id; t_d[nd] = c; nd++; end
    end
    n_checks++; if (nd !== 6) begin n_fail++; $display("FAIL rr_done_count got %0d want 6", nd); end
    for (int i = 0; i < nd; i++) begin
      n_checks++;
      if (got_id[i] !== exp_id[i]) begin n_fail++; $display("FAIL rr_order[%0d] got %0d want %0d", i, got_id[i], exp_id[i]); end
    end
    if (nd > 0) begin
      n_checks++; if (t_d[0] !== 4) begin n_fail++; $display("FAIL rr_first_done got %0d want 4", t_d[0]); end
    end
    for (int i = 1; i < nd; i++) begin
      n_checks++;
      if (t_d[i] - t_d[i-1] !== 6) begin n_fail++; $display("FAIL rr_spacing[%0d] got %0d want 6", i, t_d[i] - t_d[i-1]); end
    end
  endtask

  task automatic test_cancel();
    int ts, tp, td, ov; logic [1:0] id; logic [7:0] tk; logic ab; logic [3:0] gs;
    clr_counter();
    len = 32'd10 << 16; req = 4'b0100;
    watch(4, 2, 40, ts, tp, td, id, tk, ab, gs, ov);
    @(posedge clk); #1 req = '0;
    n_checks++; if (gs !== 4'b0100)   begin n_fail++; $display("FAIL cancel_grant got %b want 0100", gs); end
    n_checks++; if (tp !== 4)         begin n_fail++; $display("FAIL cancel_stop_cyc got %0d want 4", tp); end
    n_checks++; if (td !== 7)         begin n_fail++; $display("FAIL cancel_done_cyc got %0d want 7", td); end
    n_checks++; if (id !== 2'd2)      begin n_fail++; $display("FAIL cancel_done_id got %0d want 2", id); end
    n_checks++; if (ab !== 1'b1)      begin n_fail++; $display("FAIL cancel_aborted got %b want 1", ab); end
    n_checks++; if (tk !== 8'd4)      begin n_fail++; $display("FAIL cancel_ticks got %0d want 4", tk); end
    n_checks++; if (cnt_val !== 4'd4) begin n_fail++; $display("FAIL cancel_counter got %0d want 4", cnt_val); end
  endtask

  task automatic test_zero_len();
    int ts, tp, td, ov; logic [1:0] id; logic [7:0] tk; logic ab; logic [3:0] gs;
    clr_counter();
    len = 32'h0505_0005; req = 4'b0010;  // len1 = 0
    watch(-1, 0, 20, ts, tp, td, id, tk, ab, gs, ov);
    @(posedge clk); #1 req = '0;
    n_checks++; if (ts !== -1)    begin n_fail++; $display("FAIL zero_start_seen got %0d want -1", ts); end
    n_checks++; if (td !== 0)     begin n_fail++; $display("FAIL zero_done_cyc got %0d want 0", td); end
    n_checks++; if (id !== 2'd1)  begin n_fail++; $display("FAIL zero_done_id got %0d want 1", id); end
    n_checks++; if (tk !== 8'd0)  begin n_fail++; $display("FAIL zero_ticks got %0d want 0", tk); end
    n_checks++; if (ab !== 1'b0)  begin n_fail++; $display("FAIL zero_aborted got %b want 0", ab); end
  endtask

  task automatic test_tie();
    int ts, tp, td, ov; logic [1:0] id; logic [7:0] tk; logic ab; logic [3:0] gs;
    // cancel coincides with last RUN cycle: normal end wins
    clr_counter();
    len = 32'd3; req = 4'b0001;
    watch(3, 0, 30, ts, tp, td, id, tk, ab, gs, ov);
    @(posedge clk); #1 req = '0;
    n_checks++; if (ab !== 1'b0) begin n_fail++; $display("FAIL tie_last_aborted got %b want 0", ab); end
    n_checks++; if (tk !== 8'd3) begin n_fail++; $display("FAIL tie_last_ticks got %0d want 3", tk); end
    // cancel one cycle earlier is a real abort
    clr_counter();
    len = 32'd3; req = 4'b0001;
    watch(2, 0, 30, ts, tp, td, id, tk, ab, gs, ov);
    @(posedge clk); #1 req = '0;
    n_checks++; if (ab !== 1'b1) begin n_fail++; $display("FAIL tie_early_aborted got %b want 1", ab); end
    n_checks++; if (tk !== 8'd2) begin n_fail++; $display("FAIL tie_early_ticks got %0d want 2", tk); end
    n_checks++; if (tp !== 2)    begin n_fail++; $display("FAIL tie_early_stop_cyc got %0d want 2", tp); end
  endtask

  task automatic test_watchdog();
    int ts, tp, td, ov; logic [1:0] id; logic [7:0] tk; logic ab; logic [3:0] gs;
    clr_counter();
    d2_low = 1'b1;
    len = 32'd2; req = 4'b0001;
    watch(-1, 0, 30, ts, tp, td, id, tk, ab, gs, ov);
    @(posedge clk); #1 req = '0;
    d2_low = 1'b0;
    n_checks++; if (tp !== 2)    begin n_fail++; $display("FAIL wdog_stop_cyc got %0d want 2", tp); end
    n_checks++; if (td !== 7)    begin n_fail++; $display("FAIL wdog_done_cyc got %0d want 7", td); end
    n_checks++; if (ab !== 1'b1) begin n_fail++; $display("FAIL wdog_aborted got %b want 1", ab); end
    n_checks++; if (tk !== 8'd2) begin n_fail++; $display("FAIL wdog_ticks got %0d want 2", tk); end
  endtask

  task automatic test_reset_mid_run();
    int n_stop = 0;
    logic seen_busy = 1'b0;
    clr_counter();
    len = 32'd10; req = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 3) rst = 1'b1;
      if (c == 4) begin rst = 1'b0; req = '0; end
      @(negedge clk);
      if (c >= 3 && cnt_stop) n_stop++;
      if (c == 2) seen_busy = busy;
      if (c == 4) begin
        n_checks++; if (grant !== 4'b0)   begin n_fail++; $display("FAIL rstrun_grant got %b want 0000", grant); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rstrun_busy got %b want 0", busy); end
        n_checks++; if ({done, aborted, cnt_start, cnt_stop} !== 4'b0) begin n_fail++; $display("FAIL rstrun_flags got %b want 0000", {done, aborted, cnt_start, cnt_stop}); end
        n_checks++; if (ticks !== 8'd0)   begin n_fail++; $display("FAIL rstrun_ticks got %0d want 0", ticks); end
        n_checks++; if (done_id !== 2'd0) begin n_fail++; $display("FAIL rstrun_done_id got %0d want 0", done_id); end
      end
      if (c == 5) begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstrun_idle got %b want 0", busy); end
      end
    end
    n_checks++; if (seen_busy !== 1'b1) begin n_fail++; $display("FAIL rstrun_was_running got %b want 1", seen_busy); end
    n_checks++; if (n_stop !== 0)       begin n_fail++; $display("FAIL rstrun_stop_pulses got %0d want 0", n_stop); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_cancel();
    test_zero_len();
    test_tie();
    test_watchdog();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
